cpld3_row_stage: RTL and testbench
==================================

Name: cpld3_row_stage

Overview:
- One stage of a chain of row-buffer slices feeding a scanned 8-row x 5-column LED/pixel matrix.
- Each clock, the stage swaps the addressed row: it stores the 5-bit word arriving from the left neighbour and forwards the word previously held in that row to the right neighbour. Data therefore moves one stage per visit of a row.
- It also forwards the row index together with a cursor-hit flag, and flags the last row, so downstream stages and the display driver stay cycle-aligned.

Parameters:
- ROWS, 8, number of stored rows; sel addresses 0..ROWS-1.
- COLS, 5, bits per row; width of left_in2 and right_out2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- left_in2  input  5  row word from the left neighbour stage.
- sel  input  3  row index currently being scanned/swapped.
- sel_out2  output  4  registered {hit, sel}, forwarded to the next stage.
- right_out2  output  5  registered previous content of row sel, sent to the right neighbour.
- pos_c  input  3  cursor column; 0..4 valid, 5..7 means no cursor.
- last_row  output  1  registered; high when the row just forwarded is row 7.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Storage: mem[0..7], each 5 bits.
- Reset (rst=0, asynchronous, no clock needed):
  - all mem rows = 0;
  - right_out2 = 0, sel_out2 = 0, last_row = 0.
  - These values hold while rst is low.
- Each rising clk edge with rst=1:
  - right_out2 <= mem[sel] (old value, read-before-write);
  - mem[sel] <= left_in2;
  - hit = (pos_c < 5) AND mem[sel][pos_c] (old value);
  - sel_out2 <= {hit, sel};
  - last_row <= (sel == 7).
- Latency:
  - All outputs are registered and become valid 1 cycle after sel is presented.
  - A word written to row r appears on right_out2 on the clock edge of the next cycle that addresses row r.
- Unaddressed rows keep their value.
- Bit ordering: bit i of a row word is column i. pos_c indexes that bit directly.
- No handshake. Every cycle is one swap, with no enable and no stall.
- Boundary conditions:
  - The same sel on consecutive cycles swaps the same row. Cycle 2 outputs the word written in cycle 1.
  - pos_c = 5, 6 or 7: hit is forced to 0, with no out-of-range index.
  - Reset asserted mid-scan: everything clears immediately. The first cycle after release outputs zeros for any row read.
  - Reset released: the first rising edge with rst=1 performs a normal swap.
- Implementation: purely synchronous apart from the asynchronous reset. No combinational path from inputs to outputs.

Test Plan:
1. Reset: hold rst=0 with random inputs and toggling clk. Required: right_out2=0, sel_out2=0, last_row=0 throughout. After release, reading any row gives right_out2=0.
2. Write then read back:
   - Cycle 1: sel=3, left_in2=5'b10110.
   - Cycle 2: sel=3, left_in2=0. Required: right_out2=5'b10110, sel_out2[2:0]=3, last_row=0.
3. Full sweep:
   - Write rows 0..7 with values 1..8 (sel=r, left_in2=r+1).
   - Sweep sel=0..7 again. Required: right_out2 equals 1..8 in order. last_row=1 only for the row-7 output, one cycle after sel=7.
4. Cursor hit:
   - Store 5'b01000 in row 2.
   - Read row 2 with pos_c=3: required sel_out2=4'b1010.
   - Repeat with pos_c=2: required sel_out2=4'b0010.
   - Repeat with pos_c=6: required sel_out2=4'b0010 (hit forced to 0 whatever the stored bits).
5. Asynchronous reset mid-operation: rows hold data; drop rst between clock edges. Required: outputs go to 0 before the next edge, and a subsequent read of any row returns 0.
6. Isolation: write row 1 = 5'b11111, then write rows 0 and 2..7 repeatedly. Required: a later read of row 1 returns 5'b11111.

Source files
------------

// File: rtl/cpld3_row_stage_if.sv
// Bus between one row-buffer stage and its neighbours: the word and row index
// arriving from the left, and the registered word, {hit, sel} and last-row
// flag leaving to the right.
interface cpld3_row_stage_if #(
    parameter int ROWS = 8,
    parameter int COLS = 5
);
    localparam int SEL_W = $clog2(ROWS);

    logic [COLS-1:0]  left_in2;
    logic [SEL_W-1:0] sel;
    logic [2:0]       pos_c;
    logic [SEL_W:0]   sel_out2;
    logic [COLS-1:0]  right_out2;
    logic             last_row;

    // Upstream side: drives the scan inputs and observes the forwarded outputs.
    modport master (
        output left_in2, sel, pos_c,
        input  sel_out2, right_out2, last_row
    );

    // Stage side: consumes the scan inputs and produces the registered outputs.
    modport slave (
        input  left_in2, sel, pos_c,
        output sel_out2, right_out2, last_row
    );
endinterface

// File: rtl/cpld3_row_stage.sv
// One slice of a chained row buffer for a scanned LED/pixel matrix. Every
// clock it swaps the addressed row: the incoming word is stored and the word
// previously held there is forwarded right, together with the row index, a
// cursor-hit flag taken from the old word, and a last-row marker.
module cpld3_row_stage #(
    parameter int ROWS = 8,
    parameter int COLS = 5
) (
    input  logic               clk,
    input  logic               rst,
    cpld3_row_stage_if.slave   bus
);
    localparam int SEL_W = $clog2(ROWS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(ROWS - 1);

    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] old_word;
    logic            hit;

    // Old contents of the addressed row and the cursor bit within it; the
    // cursor is matched column by column so pos_c values beyond the last
    // column never index past the word and simply give no hit.
    always_comb begin
        old_word = mem[bus.sel];
        hit      = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (bus.pos_c == 3'(i)) begin
                hit = old_word[i];
            end
        end
    end

    // Read-before-write swap of the addressed row, with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
            end
            bus.right_out2 <= '0;
            bus.sel_out2   <= '0;
            bus.last_row   <= 1'b0;
        end else begin
            bus.right_out2   <= old_word;
            mem[bus.sel]     <= bus.left_in2;
            bus.sel_out2     <= {hit, bus.sel};
            bus.last_row     <= (bus.sel == LAST_SEL);
        end
    end
endmodule

// File: tb/tb_cpld3_row_stage.sv
// Directed bench for cpld3_row_stage: reset behaviour, read-back latency,
// full row sweep, cursor hit decoding, asynchronous reset and row isolation.
module tb_cpld3_row_stage;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    cpld3_row_stage_if #(.ROWS(8), .COLS(5)) ifc ();

    cpld3_row_stage #(.ROWS(8), .COLS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present one swap on the falling edge, then sample 1 unit after the rise.
    task automatic cycle(input logic [2:0] s, input logic [4:0] d,
                         input logic [2:0] pc);
        @(negedge clk);
        ifc.sel      = s;
        ifc.left_in2 = d;
        ifc.pos_c    = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        ifc.sel      = '0;
        ifc.left_in2 = '0;
        ifc.pos_c    = 3'd7;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held with random inputs and a running clock.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ifc.sel      = 3'($urandom);
            ifc.left_in2 = 5'($urandom);
            ifc.pos_c    = 3'($urandom);
            @(posedge clk);
            #1;
            check_vec("rst_right", 32'(ifc.right_out2), 32'h0);
            check_vec("rst_sel",   32'(ifc.sel_out2),   32'h0);
            check_vec("rst_last",  32'(ifc.last_row),   32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        cycle(3'd5, 5'b00000, 3'd7);
        check_vec("post_rst_read", 32'(ifc.right_out2), 32'h0);

        // Write then immediate read-back of row 3.
        cycle(3'd3, 5'b10110, 3'd7);
        cycle(3'd3, 5'b00000, 3'd7);
        check_vec("wr_rd_right", 32'(ifc.right_out2), 32'h16);
        check_vec("wr_rd_sel",   32'(ifc.sel_out2),   32'h3);
        check_vec("wr_rd_last",  32'(ifc.last_row),   32'h0);

        // Full sweep: write 1..8, then read them back in order.
        for (int r = 0; r < 8; r++) cycle(3'(r), 5'(r + 1), 3'd7);
        for (int r = 0; r < 8; r++) begin
            cycle(3'(r), 5'b00000, 3'd7);
            check_vec($sformatf("sweep_right_%0d", r), 32'(ifc.right_out2), 32'(r + 1));
            check_vec($sformatf("sweep_last_%0d", r),  32'(ifc.last_row),   32'(r == 7));
            check_vec($sformatf("sweep_sel_%0d", r),   32'(ifc.sel_out2),   32'(r));
        end

        // Cursor hit on row 2 holding 5'b01000.
        cycle(3'd2, 5'b01000, 3'd7);
        cycle(3'd2, 5'b01000, 3'd3);
        check_vec("hit_pc3", 32'(ifc.sel_out2), 32'hA);
        cycle(3'd2, 5'b01000, 3'd2);
        check_vec("hit_pc2", 32'(ifc.sel_out2), 32'h2);
        cycle(3'd2, 5'b11111, 3'd6);
        check_vec("hit_pc6", 32'(ifc.sel_out2), 32'h2);
        // Row 2 now holds 5'b11111: out-of-range cursor still gives no hit.
        cycle(3'd2, 5'b10001, 3'd5);
        check_vec("hit_pc5", 32'(ifc.sel_out2), 32'h2);
        // Row 2 now holds 5'b10001: edge columns 4 and 0.
        cycle(3'd2, 5'b10001, 3'd4);
        check_vec("hit_pc4", 32'(ifc.sel_out2), 32'hA);
        cycle(3'd2, 5'b10001, 3'd0);
        check_vec("hit_pc0", 32'(ifc.sel_out2), 32'hA);
        cycle(3'd2, 5'b10001, 3'd1);
        check_vec("hit_pc1", 32'(ifc.sel_out2), 32'h2);

        // Fill all rows with nonzero data, then reset between clock edges.
        for (int r = 0; r < 8; r++) cycle(3'(r), 5'(r + 9), 3'd7);
        cycle(3'd7, 5'b00000, 3'd0);
        check_vec("pre_arst_right", 32'(ifc.right_out2), 32'h10);
        check_vec("pre_arst_sel",   32'(ifc.sel_out2),   32'h7);
        check_vec("pre_arst_last",  32'(ifc.last_row),   32'h1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_vec("arst_right", 32'(ifc.right_out2), 32'h0);
        check_vec("arst_sel",   32'(ifc.sel_out2),   32'h0);
        check_vec("arst_last",  32'(ifc.last_row),   32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 8; r++) begin
            cycle(3'(r), 5'b00000, 3'd7);
            check_vec($sformatf("arst_read_%0d", r), 32'(ifc.right_out2), 32'h0);
        end

        // Isolation: row 1 survives repeated writes to every other row.
        cycle(3'd1, 5'b11111, 3'd7);
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++) begin
                if (r != 1) cycle(3'(r), 5'($urandom), 3'($urandom));
            end
        end
        cycle(3'd1, 5'b00000, 3'd0);
        check_vec("iso_right", 32'(ifc.right_out2), 32'h1F);
        check_vec("iso_sel",   32'(ifc.sel_out2),   32'h9);
        check_vec("iso_last",  32'(ifc.last_row),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
